// File: rtl/fp32_pkg.sv
// Shared fp32 field widths, converter state encoding and word packing.
package fp32_pkg;

  localparam int unsigned FP32_EXP_W  = 8;
  localparam int unsigned FP32_MANT_W = 23;
  localparam int unsigned FP32_BIAS   = 127;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } conv_state_t;

  function automatic logic [31:0] fp32_pack(input logic                   sign,
                                            input logic [FP32_EXP_W-1:0]  exp,
                                            input logic [FP32_MANT_W-1:0] mant);
    return {sign, exp, mant};
  endfunction

endpackage

// File: rtl/fp32_round_pack.sv
// Round-nearest-even of a normalized 32-bit magnitude into a packed fp32 word.
module fp32_round_pack
  import fp32_pkg::*;
(
  input  logic                  sign,
  input  logic [FP32_EXP_W-1:0] exp,
  input  logic [31:0]           mag,
  output logic [31:0]           result,
  output logic                  inexact
);

  logic [FP32_MANT_W-1:0] mant;
  logic                   guard;
  logic                   sticky;
  logic                   round_up;
  logic [FP32_MANT_W:0]   mant_inc;
  logic [FP32_EXP_W-1:0]  exp_adj;

  always_comb begin
    mant     = mag[30:8];
    guard    = mag[7];
    sticky   = |mag[6:0];
    round_up = guard & (sticky | mant[0]);
    mant_inc = {1'b0, mant} + (FP32_MANT_W + 1)'(round_up);
    // Carry out of the mantissa leaves it all-zero; bump the exponent instead.
    exp_adj  = exp + FP32_EXP_W'(mant_inc[FP32_MANT_W]);
    inexact  = guard | sticky;
    // A clear hidden bit means a zero magnitude, which packs as +0.
    result   = mag[31] ? fp32_pack(sign, exp_adj, mant_inc[FP32_MANT_W-1:0]) : 32'h0;
  end

endmodule

// File: rtl/int_to_float_conv.sv
// Sequential int32 -> fp32 converter: one-bit-per-cycle normalize, then RNE rounding.
module int_to_float_conv
  import fp32_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned FP_BIAS = 127
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_data,
  input  logic            in_signed,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     result,
  output logic            out_inexact
);

  // Exponent of a value whose leading one sits at bit XLEN-1.
  localparam logic [FP32_EXP_W-1:0] ExpInit = FP32_EXP_W'(FP_BIAS + XLEN - 1);

  conv_state_t           state_q;
  logic [XLEN-1:0]       mag_q;
  logic [FP32_EXP_W-1:0] exp_q;
  logic                  sign_q;
  logic [31:0]           result_q;
  logic                  inexact_q;
  logic                  out_valid_q;

  logic                  in_sign;
  logic [XLEN-1:0]       in_mag;
  logic [31:0]           rp_result;
  logic                  rp_inexact;

  // 0x80000000 signed negates to itself, which is the correct unsigned magnitude.
  always_comb begin
    in_sign = in_signed & in_data[XLEN-1];
    in_mag  = in_sign ? (~in_data + XLEN'(1)) : in_data;
  end

  fp32_round_pack u_round_pack (
    .sign    (sign_q),
    .exp     (exp_q),
    .mag     (mag_q),
    .result  (rp_result),
    .inexact (rp_inexact)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      result_q    <= 32'h0;
      inexact_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q <= in_sign;
            mag_q  <= in_mag;
            exp_q  <= ExpInit;
            if (in_mag == '0) begin
              result_q    <= 32'h0;
              inexact_q   <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= NORM;
            end
          end
        end
        NORM: begin
          if (!mag_q[XLEN-1]) begin
            mag_q <= mag_q << 1;
            exp_q <= exp_q - FP32_EXP_W'(1);
          end else begin
            state_q <= ROUND;
          end
        end
        ROUND: begin
          result_q    <= rp_result;
          inexact_q   <= rp_inexact;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign out_inexact = inexact_q;

endmodule

// File: tb/tb_int_to_float_conv.sv
// Self-checking bench for int_to_float_conv: directed corners plus randomized operands.
module tb_int_to_float_conv;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        out_inexact;

  int n_checks;
  int n_errors;

  int_to_float_conv #(
    .XLEN    (32),
    .FP_BIAS (127)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_signed   (in_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .out_inexact (out_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: {inexact, fp32 word} from exact integer arithmetic.
  function automatic logic [32:0] ref_model(input logic [31:0] d, input logic s);
    longint unsigned mag, q, r, half;
    int              p, e;
    logic            neg;
    logic [7:0]      e8;
    logic [22:0]     m23;
    neg = s && d[31];
    mag = neg ? ((64'd1 << 32) - 64'(d)) : 64'(d);
    if (mag == 0) return 33'h0;
    p = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    e = 127 + p;
    r = 0;
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      q    = mag >> (p - 23);
      r    = mag & ((64'd1 << (p - 23)) - 1);
      half = 64'd1 << (p - 24);
      if (r > half || (r == half && q[0])) q = q + 1;
    end
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    e8  = e[7:0];
    m23 = q[22:0];
    return {r != 0, neg, e8, m23};
  endfunction

  // Edges from accept to out_valid: lz+3 for nonzero magnitudes, 1 for zero.
  function automatic int ref_latency(input logic [31:0] d, input logic s);
    longint unsigned mag;
    int              p;
    mag = (s && d[31]) ? ((64'd1 << 32) - 64'(d)) : 64'(d);
    if (mag == 0) return 1;
    p = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    return (31 - p) + 3;
  endfunction

  // Called #1 after the accept edge; waits (bounded) for out_valid and checks the result.
  task automatic wait_result(input string tag, input int exp_lat, input logic [32:0] exp_v);
    int lat;
    bit busy_ok;
    lat     = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 60) begin
      if (in_ready) busy_ok = 1'b0;
      in_data = $urandom;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy in_ready"}, {31'd0, busy_ok}, 32'd1);
    check({tag, " in_ready at valid"}, {31'd0, in_ready}, 32'd0);
    check({tag, " result"}, result, exp_v[31:0]);
    check({tag, " inexact"}, {31'd0, out_inexact}, {31'd0, exp_v[32]});
  endtask

  task automatic run_conv(input string tag, input logic [31:0] d, input logic s,
                          input logic [32:0] exp_v);
    check({tag, " in_ready idle"}, {31'd0, in_ready}, 32'd1);
    in_data   = d;
    in_signed = s;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    wait_result(tag, ref_latency(d, s), exp_v);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " out_valid drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] a_exp;
    logic [31:0] rd;
    logic        rs;
    int          seen;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    in_signed = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset result", result, 32'h0);
    check("reset inexact", {31'd0, out_inexact}, 32'd0);
    rst_n = 1'b1;

    run_conv("u1", 32'h0000_0001, 1'b0, {1'b0, 32'h3F80_0000});
    run_conv("s-1", 32'hFFFF_FFFF, 1'b1, {1'b0, 32'hBF80_0000});
    run_conv("smin", 32'h8000_0000, 1'b1, {1'b0, 32'hCF00_0000});
    run_conv("u0", 32'h0000_0000, 1'b0, {1'b0, 32'h0000_0000});
    run_conv("tie_even", 32'h0100_0001, 1'b0, {1'b1, 32'h4B80_0000});
    run_conv("tie_odd", 32'h0100_0003, 1'b0, {1'b1, 32'h4B80_0002});
    run_conv("exact24", 32'h00FF_FFFF, 1'b0, {1'b0, 32'h4B7F_FFFF});
    run_conv("mant_ovf", 32'hFFFF_FFFF, 1'b0, {1'b1, 32'h4F80_0000});

    // Back-pressure: result must hold while a new operand waits on in_valid.
    in_data   = 32'h0000_1234;
    in_signed = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    a_exp     = ref_model(32'h0000_1234, 1'b0) & 33'hFFFF_FFFF;
    wait_result("bp_a", ref_latency(32'h0000_1234, 1'b0), ref_model(32'h0000_1234, 1'b0));
    in_data   = 32'hFFFF_FC18;
    in_signed = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp hold result", result, a_exp);
      check("bp hold in_ready", {31'd0, in_ready}, 32'd0);
      check("bp hold out_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp release out_valid", {31'd0, out_valid}, 32'd0);
    check("bp release in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result("bp_b", ref_latency(32'hFFFF_FC18, 1'b1), ref_model(32'hFFFF_FC18, 1'b1));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset during normalization of 1 must drop the operand entirely.
    in_data   = 32'h0000_0001;
    in_signed = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst result", result, 32'h0);
    check("midrst inexact", {31'd0, out_inexact}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midrst no stale output", 32'(seen), 32'd0);

    // Randomized operands spread across all leading-zero counts.
    for (int i = 0; i < 60; i++) begin
      rd = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) rd = 32'h0;
      rs = 1'($urandom_range(0, 1));
      run_conv($sformatf("rnd%0d", i), rd, rs, ref_model(rd, rs));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
